shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one DATA_WIDTH-bit logical/arithmetic shifter between two requesters (port 0: integer ALU issue, port 1: bitfield/address unit) using valid/ready handshakes and round-robin arbitration. Each accepted operation is computed by the team's existing combinational `Shift` module. The result is registered into a one-deep response buffer owned by the winning requester. The block sits between the issue stage and the shared shifter, replacing per-unit shifter copies.

## Interface
- DATA_WIDTH, 64, operand/result width
- SHAMT_WIDTH, 6, shift-amount bits used ($clog2(DATA_WIDTH))
- in_clk  input  1  clock, all state on rising edge
- in_rst_n  input  1  reset, asynchronous, active-low
- in_req0_valid / in_req1_valid  input  1  request present
- out_req0_ready / out_req1_ready  output  1  request accepted this cycle
- in_req0_numA / in_req1_numA  input  DATA_WIDTH  operand
- in_req0_shamt / in_req1_shamt  input  SHAMT_WIDTH  shift amount
- in_req0_op / in_req1_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through
- out_rsp0_valid / out_rsp1_valid  output  1  result buffered
- out_rsp0_data / out_rsp1_data  output  DATA_WIDTH  result
- in_rsp0_ready / in_rsp1_ready  input  1  consumer takes result
- out_busy  output  1  any response buffer full

## Operation
- Per port k: can_accept_k = !rsp_valid_k || in_rspk_ready (drain and refill in the same cycle allowed).
- eligible_k = in_reqk_valid && can_accept_k. At most one grant per cycle.
- Round-robin pointer prio (1 bit, reset 0). If both are eligible, the port equal to prio wins. If one is eligible, it wins regardless of prio.
- On grant to k, prio <= ~k. No grant: prio holds.
- out_reqk_ready = grant_k. A handshake is valid && ready. Requesters must not make valid depend on ready, and must hold valid/operands stable until accepted.
- Datapath: granted port's numA/shamt/op are muxed into `Shift`; shamt is zero-extended to DATA_WIDTH. op[1]=SRA selects arithmetic (in_ctrl=1); op 00 takes out_LeftShift; 01/10 take out_RightShift; 11 returns numA unchanged.
- Shift amounts are only SHAMT_WIDTH bits, so no amount ≥ DATA_WIDTH is possible. Shift by 0 returns numA.
- Response buffer k: on grant_k, rsp_data_k <= result and rsp_valid_k <= 1. Else if in_rspk_ready && rsp_valid_k, then rsp_valid_k <= 0. rsp_data holds while valid and not drained.
- out_busy = rsp_valid_0 || rsp_valid_1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): rsp_valid_0/1=0, rsp_data_0/1=0, prio=0, out_busy=0. out_reqk_ready is combinational and 0 while in_rst_n low.
- Latency: request accepted in cycle N -> out_rspk_valid=1 with data in cycle N+1.
- Throughput: one operation per cycle total. A single requester with always-ready consumer gets one result per cycle. Two contending requesters alternate.
- Stalled consumer: rsp_valid_k holds, out_reqk_ready=0 for port k, and the other port still gets grants every cycle.
- Simultaneous drain+grant on the same port: new data overwrites, valid stays 1, no bubble.
- Reset mid-operation: buffered results are discarded, and requesters must reissue.
- Fairness: a continuously eligible port waits at most 1 cycle for a grant.

## Structure
- Package shift_arb_pkg: op encoding localparams (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_PASS=2'b11) and the default width constants. The issue stage imports the same package.
- One sub-module instance: the existing `Shift` (DATA_WIDTH passed through). Arbitration, mux and response buffers stay in shift_arbiter. A separate arbiter module is not warranted for two ports.

## Test plan
- Reset: hold in_rst_n=0 with both valids high -> readies 0, rsp_valid 0, busy 0. After release, the first contention cycle grants port 0.
- Ops on port 0, rsp ready: numA=64'h8000_0000_0000_00F0, shamt=4 -> SLL 64'h0000_0000_0000_0F00, SRL 64'h0800_0000_0000_000F, SRA 64'hF800_0000_0000_000F, PASS unchanged. Each result appears 1 cycle after accept.
- Contention: both valid for 4 cycles, consumers ready -> grants 0,1,0,1 with prio toggling. Each port gets 2 correct results.
- Backpressure: in_rsp0_ready=0 after the first port-0 result -> out_req0_ready stays 0 and rsp0_data is stable. Port 1 is granted every cycle. Raising in_rsp0_ready gives a drain and a new grant in the same cycle.
- Edge amounts: shamt=0 returns numA; shamt=63 SRA of 64'h8000_0000_0000_0000 -> all ones; shamt=63 SLL of 1 -> 64'h8000_0000_0000_0000.
- Async reset mid-stream: assert in_rst_n between clock edges while both buffers are full -> outputs clear immediately, with no response emitted after release.

Source files
------------

// File: rtl/shift_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_arb_pkg
//  Purpose  : Shared definitions for the shared-shifter arbiter. The issue
//             stage imports this package too, so op encodings stay in one
//             place.
//  Contents : op encodings (OP_SLL/OP_SRL/OP_SRA/OP_PASS), default widths.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_arb_pkg;

  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_SHAMT_WIDTH = $clog2(DEF_DATA_WIDTH);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

endpackage : shift_arb_pkg
`default_nettype wire

// File: rtl/shift_arbiter_shift.sv
`default_nettype none
// ============================================================================
//  Module   : Shift
//  Purpose  : Combinational barrel shifter. Produces the left and right shift
//             of in_numA by in_shamt; in_ctrl=1 makes the right shift
//             arithmetic (sign-filling), 0 makes it logical.
//  Ports    : in_numA        [DATA_WIDTH] operand
//             in_shamt       [DATA_WIDTH] shift amount (already zero-extended)
//             in_ctrl        1 = arithmetic right shift
//             out_LeftShift  [DATA_WIDTH] in_numA << in_shamt
//             out_RightShift [DATA_WIDTH] in_numA >> / >>> in_shamt
//  Revision : 1.0 - initial release
// ============================================================================
module Shift #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] in_numA,
  input  logic [DATA_WIDTH-1:0] in_shamt,
  input  logic                  in_ctrl,
  output logic [DATA_WIDTH-1:0] out_LeftShift,
  output logic [DATA_WIDTH-1:0] out_RightShift
);

  always_comb begin
    out_LeftShift = in_numA << in_shamt;
    if (in_ctrl) begin
      out_RightShift = DATA_WIDTH'($signed(in_numA) >>> in_shamt);
    end else begin
      out_RightShift = in_numA >> in_shamt;
    end
  end

endmodule : Shift
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_arbiter
//  Purpose  : Shares one Shift instance between two requesters (port 0: ALU
//             issue, port 1: bitfield/address unit). Round-robin arbitration,
//             at most one grant per cycle, result registered into a one-deep
//             response buffer owned by the winning port.
//  Ports    : in_clk / in_rst_n           clock, async active-low reset
//             in_reqK_valid/out_reqK_ready request handshake (K = 0,1)
//             in_reqK_numA/shamt/op       operand, shift amount, op code
//             out_rspK_valid/data         buffered result
//             in_rspK_ready               consumer takes result
//             out_busy                    any response buffer full
//  Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
  input  logic                   in_clk,
  input  logic                   in_rst_n,

  input  logic                   in_req0_valid,
  output logic                   out_req0_ready,
  input  logic [DATA_WIDTH-1:0]  in_req0_numA,
  input  logic [SHAMT_WIDTH-1:0] in_req0_shamt,
  input  logic [1:0]             in_req0_op,

  input  logic                   in_req1_valid,
  output logic                   out_req1_ready,
  input  logic [DATA_WIDTH-1:0]  in_req1_numA,
  input  logic [SHAMT_WIDTH-1:0] in_req1_shamt,
  input  logic [1:0]             in_req1_op,

  output logic                   out_rsp0_valid,
  output logic [DATA_WIDTH-1:0]  out_rsp0_data,
  input  logic                   in_rsp0_ready,

  output logic                   out_rsp1_valid,
  output logic [DATA_WIDTH-1:0]  out_rsp1_data,
  input  logic                   in_rsp1_ready,

  output logic                   out_busy
);

  logic                  r_rspValid0, r_rspValid1;
  logic [DATA_WIDTH-1:0] r_rspData0,  r_rspData1;
  logic                  r_prio;

  logic                   w_elig0, w_elig1;
  logic                   w_grant0, w_grant1;
  logic [DATA_WIDTH-1:0]  w_selNumA;
  logic [SHAMT_WIDTH-1:0] w_selShamt;
  logic [1:0]             w_selOp;
  logic [DATA_WIDTH-1:0]  w_shamtExt;
  logic [DATA_WIDTH-1:0]  w_left, w_right;
  logic [DATA_WIDTH-1:0]  w_result;

  // A port may be granted if its buffer is empty or is being drained this
  // cycle. Gating with in_rst_n keeps readies low during reset even though
  // the (cleared) buffers would otherwise look free.
  always_comb begin
    w_elig0 = in_rst_n && in_req0_valid && (!r_rspValid0 || in_rsp0_ready);
    w_elig1 = in_rst_n && in_req1_valid && (!r_rspValid1 || in_rsp1_ready);
    // Lone eligible port wins outright; on contention r_prio picks.
    w_grant0 = w_elig0 && (!w_elig1 || !r_prio);
    w_grant1 = w_elig1 && (!w_elig0 ||  r_prio);
  end

  assign out_req0_ready = w_grant0;
  assign out_req1_ready = w_grant1;

  // Operand mux; port 0 is the idle default, the result is only captured
  // on a grant so the idle selection is irrelevant.
  always_comb begin
    w_selNumA  = w_grant1 ? in_req1_numA  : in_req0_numA;
    w_selShamt = w_grant1 ? in_req1_shamt : in_req0_shamt;
    w_selOp    = w_grant1 ? in_req1_op    : in_req0_op;
    w_shamtExt = DATA_WIDTH'(w_selShamt);
  end

  Shift #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .in_numA        (w_selNumA),
    .in_shamt       (w_shamtExt),
    .in_ctrl        (w_selOp[1]),
    .out_LeftShift  (w_left),
    .out_RightShift (w_right)
  );

  always_comb begin
    w_result = w_selNumA;
    case (w_selOp)
      OP_SLL:  w_result = w_left;
      OP_SRL:  w_result = w_right;
      OP_SRA:  w_result = w_right;
      default: w_result = w_selNumA;
    endcase
  end

  // A grant takes precedence over a drain: refilling in the drain cycle keeps
  // valid high with no bubble.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_rspValid0 <= 1'b0;
      r_rspValid1 <= 1'b0;
      r_rspData0  <= '0;
      r_rspData1  <= '0;
      r_prio      <= 1'b0;
    end else begin
      if (w_grant0) begin
        r_rspData0  <= w_result;
        r_rspValid0 <= 1'b1;
      end else if (in_rsp0_ready && r_rspValid0) begin
        r_rspValid0 <= 1'b0;
      end

      if (w_grant1) begin
        r_rspData1  <= w_result;
        r_rspValid1 <= 1'b1;
      end else if (in_rsp1_ready && r_rspValid1) begin
        r_rspValid1 <= 1'b0;
      end

      if (w_grant0) begin
        r_prio <= 1'b1;
      end else if (w_grant1) begin
        r_prio <= 1'b0;
      end
    end
  end

  assign out_rsp0_valid = r_rspValid0;
  assign out_rsp0_data  = r_rspData0;
  assign out_rsp1_valid = r_rspValid1;
  assign out_rsp1_data  = r_rspData1;
  assign out_busy       = r_rspValid0 || r_rspValid1;

endmodule : shift_arbiter
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_arbiter
//  Purpose  : Directed self-checking bench for shift_arbiter. Inputs change
//             on the falling edge; readies are checked 1 ns later, buffered
//             results 1 ns after the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;
  import shift_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        v0, v1, rdy0, rdy1, rr0, rr1;
  logic [63:0] a0, a1, d0, d1;
  logic [5:0]  s0, s1;
  logic [1:0]  o0, o1;
  logic        rv0, rv1, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.DATA_WIDTH(64), .SHAMT_WIDTH(6)) dut (
    .in_clk(clk), .in_rst_n(rstN),
    .in_req0_valid(v0), .out_req0_ready(rdy0), .in_req0_numA(a0),
    .in_req0_shamt(s0), .in_req0_op(o0),
    .in_req1_valid(v1), .out_req1_ready(rdy1), .in_req1_numA(a1),
    .in_req1_shamt(s1), .in_req1_op(o1),
    .out_rsp0_valid(rv0), .out_rsp0_data(d0), .in_rsp0_ready(rr0),
    .out_rsp1_valid(rv1), .out_rsp1_data(d1), .in_rsp1_ready(rr1),
    .out_busy(busy)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic v, input logic [63:0] a, input logic [5:0] s, input logic [1:0] o);
    v0 = v; a0 = a; s0 = s; o0 = o;
  endtask

  task automatic set1(input logic v, input logic [63:0] a, input logic [5:0] s, input logic [1:0] o);
    v1 = v; a1 = a; s1 = s; o1 = o;
  endtask

  task automatic test_reset();
    rstN = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    set0(1'b1, 64'h11, 6'd0, OP_PASS);
    set1(1'b1, 64'h22, 6'd0, OP_PASS);
    @(negedge clk); @(negedge clk); #1;
    total++; if ({rdy0, rdy1} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {rdy0, rdy1}); end
    total++; if ({rv0, rv1, busy} !== 3'b000) begin bad++; $display("FAIL reset_valid_busy got=%b exp=000", {rv0, rv1, busy}); end
    total++; if ({d0, d1} !== 128'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", d0, d1); end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    total++; if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL first_contention got=%b exp=10", {rdy0, rdy1}); end
    // withdraw before the rising edge so prio stays at 0
    v0 = 1'b0; v1 = 1'b0;
    tick();
    total++; if ({rv0, rv1} !== 2'b00) begin bad++; $display("FAIL no_grant_after_withdraw got=%b exp=00", {rv0, rv1}); end
  endtask

  task automatic test_ops();
    logic [63:0] n;
    logic [63:0] exp [4];
    logic [1:0]  ops [4];
    n = 64'h8000_0000_0000_00F0;
    ops[0] = OP_SLL;  exp[0] = 64'h0000_0000_0000_0F00;
    ops[1] = OP_SRL;  exp[1] = 64'h0800_0000_0000_000F;
    ops[2] = OP_SRA;  exp[2] = 64'hF800_0000_0000_000F;
    ops[3] = OP_PASS; exp[3] = 64'h8000_0000_0000_00F0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set0(1'b1, n, 6'd4, ops[i]);
      #1;
      total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL op%0d_ready got=%b exp=1", i, rdy0); end
      tick();
      total++; if (rv0 !== 1'b1 || d0 !== exp[i]) begin bad++; $display("FAIL op%0d_result got=%b/%h exp=1/%h", i, rv0, d0, exp[i]); end
    end
    @(negedge clk); v0 = 1'b0;
    tick();
    total++; if ({rv0, busy} !== 2'b00) begin bad++; $display("FAIL ops_drain got=%b exp=00", {rv0, busy}); end
  endtask

  // prio is 1 after test_ops; one extra port-1 grant brings it back to 0
  task automatic test_contention();
    @(negedge clk); set1(1'b1, 64'h0, 6'd0, OP_PASS);
    tick();
    @(negedge clk);
    set0(1'b1, 64'h1,  6'd4, OP_SLL);
    set1(1'b1, 64'hF0, 6'd4, OP_SRL);
    #1;
    total++; if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL cont_c1_grant got=%b exp=10", {rdy0, rdy1}); end
    tick();
    total++; if (rv0 !== 1'b1 || d0 !== 64'h10) begin bad++; $display("FAIL cont_c1_rsp0 got=%b/%h exp=1/10", rv0, d0); end
    @(negedge clk); set0(1'b1, 64'h3, 6'd8, OP_SLL);
    #1;
    total++; if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL cont_c2_grant got=%b exp=01", {rdy0, rdy1}); end
    tick();
    total++; if (rv1 !== 1'b1 || d1 !== 64'hF || rv0 !== 1'b0) begin bad++; $display("FAIL cont_c2_rsp got=%b/%h rv0=%b exp=1/f rv0=0", rv1, d1, rv0); end
    @(negedge clk); set1(1'b1, 64'h8000_0000_0000_0000, 6'd4, OP_SRA);
    #1;
    total++; if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL cont_c3_grant got=%b exp=10", {rdy0, rdy1}); end
    tick();
    total++; if (d0 !== 64'h300) begin bad++; $display("FAIL cont_c3_rsp0 got=%h exp=300", d0); end
    @(negedge clk); set0(1'b1, 64'h7, 6'd1, OP_SLL);
    #1;
    total++; if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL cont_c4_grant got=%b exp=01", {rdy0, rdy1}); end
    tick();
    total++; if (d1 !== 64'hF800_0000_0000_0000) begin bad++; $display("FAIL cont_c4_rsp1 got=%h exp=f800000000000000", d1); end
    @(negedge clk); v0 = 1'b0; v1 = 1'b0;
    tick();
  endtask

  // prio is 0 here
  task automatic test_backpressure();
    @(negedge clk); set0(1'b1, 64'hAAAA, 6'd0, OP_PASS);
    tick();
    total++; if (rv0 !== 1'b1 || d0 !== 64'hAAAA) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/aaaa", rv0, d0); end
    @(negedge clk);
    rr0 = 1'b0;
    set0(1'b1, 64'h5555, 6'd0, OP_PASS);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      set1(1'b1, 64'h100 + 64'(k), 6'd0, OP_PASS);
      #1;
      total++; if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL bp_grant%0d got=%b exp=01", k, {rdy0, rdy1}); end
      tick();
      total++; if (rv0 !== 1'b1 || d0 !== 64'hAAAA || d1 !== 64'h100 + 64'(k)) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/aaaa/%h", k, rv0, d0, d1, 64'h100 + 64'(k));
      end
    end
    @(negedge clk); rr0 = 1'b1; v1 = 1'b0;
    #1;
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", rdy0); end
    tick();
    total++; if (rv0 !== 1'b1 || d0 !== 64'h5555) begin bad++; $display("FAIL bp_refill got=%b/%h exp=1/5555", rv0, d0); end
    @(negedge clk); v0 = 1'b0;
    tick();
  endtask

  task automatic test_edges();
    @(negedge clk); set0(1'b1, 64'h1234, 6'd0, OP_SLL);
    tick();
    total++; if (d0 !== 64'h1234) begin bad++; $display("FAIL edge_shamt0 got=%h exp=1234", d0); end
    @(negedge clk); set0(1'b1, 64'h8000_0000_0000_0000, 6'd63, OP_SRA);
    tick();
    total++; if (d0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL edge_sra63 got=%h exp=ffffffffffffffff", d0); end
    @(negedge clk); set0(1'b1, 64'h1, 6'd63, OP_SLL);
    tick();
    total++; if (d0 !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL edge_sll63 got=%h exp=8000000000000000", d0); end
    @(negedge clk); v0 = 1'b0; set1(1'b1, 64'h8000_0000_0000_0000, 6'd63, OP_SRL);
    tick();
    total++; if (rv1 !== 1'b1 || d1 !== 64'h1) begin bad++; $display("FAIL edge_srl63_p1 got=%b/%h exp=1/1", rv1, d1); end
    @(negedge clk); v1 = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rr0 = 1'b0; rr1 = 1'b0;
    set0(1'b1, 64'hDEAD, 6'd0, OP_PASS);
    set1(1'b1, 64'hBEEF, 6'd0, OP_PASS);
    tick(); tick();
    @(negedge clk); v0 = 1'b0; v1 = 1'b0;
    #1;
    total++; if ({rv0, rv1, busy} !== 3'b111) begin bad++; $display("FAIL ar_full got=%b exp=111", {rv0, rv1, busy}); end
    #1 rstN = 1'b0;
    #1;
    total++; if ({rv0, rv1, busy} !== 3'b000 || {d0, d1} !== 128'h0) begin
      bad++; $display("FAIL ar_clear got=%b data=%h/%h exp=000 0/0", {rv0, rv1, busy}, d0, d1);
    end
    @(negedge clk); rstN = 1'b1;
    tick(); tick();
    total++; if ({rv0, rv1, busy} !== 3'b000) begin bad++; $display("FAIL ar_after_release got=%b exp=000", {rv0, rv1, busy}); end
    rr0 = 1'b1; rr1 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_contention();
    test_backpressure();
    test_edges();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shift_arbiter
`default_nettype wire
